dram_arbiter: RTL and testbench

- Shares the single-port data RAM wrapper between the core LSU (port 0) and the DMA/debug loader (port 1).
- Arbitrates per cycle and drives the wrapper's mem_wr/mem_rd/mem_op/addr/wdata.
- Checks alignment, op code and range before any RAM access.
- Returns the 1-cycle-latency read data, or an error, to the requester that was granted.

---
 rtl/dram_pkg.sv | 33 +++
 rtl/dram_acc_check.sv | 31 +++
 rtl/dram_arbiter.sv | 122 ++++++++++++
 tb/tb_dram_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the data-RAM arbiter and the RAM wrapper:
// funct3-style op codes, port IDs and the request bundle.
package dram_pkg;

    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef struct packed {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dram_req_t;

    // Low address bits that must be zero for the access size encoded in op[1:0].
    function automatic logic [1:0] op_align_mask(input logic [2:0] op);
        case (op[1:0])
            2'b01:   return 2'b01;
            2'b10:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dram_acc_check.sv
// Combinational legality check of a single RAM request: op code valid for
// the direction, natural alignment, and address inside the RAM.
module dram_acc_check
    import dram_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        illegal
);

    logic op_ok;
    logic misalign;
    logic out_of_range;

    always_comb begin
        if (we) begin
            op_ok = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        end else begin
            op_ok = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                    (op == OP_LBU) || (op == OP_LHU);
        end
    end

    assign misalign     = |(addr[1:0] & op_align_mask(op));
    assign out_of_range = |(addr >> ADDR_W);
    assign illegal      = !op_ok || misalign || out_of_range;

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of the single-port data RAM wrapper (LSU on
// port 0, DMA/debug loader on port 1) with a one-cycle registered response.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 8
) (
    input  logic        sclk,
    input  logic        rstn,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_op,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic        p0_err,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_op,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic        p1_err,
    output logic [31:0] p1_rdata,

    output logic        mem_wr,
    output logic        mem_rd,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic       rr_last;
    logic [7:0] wait_cnt;
    logic       rsp_vld;
    logic       rsp_id;
    logic       rsp_err;
    logic       rsp_rd;

    logic       win;
    logic       gnt_any;
    logic       illegal;
    logic       legal;
    dram_req_t  win_req;

    always_comb begin
        win = PORT0;
        if (p0_req && p1_req) begin
            if (PRIO_MODE == 0) begin
                win = (rr_last == PORT0) ? PORT1 : PORT0;
            end else begin
                win = (wait_cnt == 8'(MAX_WAIT)) ? PORT1 : PORT0;
            end
        end else if (p1_req) begin
            win = PORT1;
        end
    end

    // Grants are gated by rstn so nothing reaches the RAM while reset is held.
    assign gnt_any = rstn && (p0_req || p1_req);
    assign p0_gnt  = gnt_any && (win == PORT0);
    assign p1_gnt  = gnt_any && (win == PORT1);

    assign win_req = (win == PORT1) ? {p1_we, p1_op, p1_addr, p1_wdata}
                                    : {p0_we, p0_op, p0_addr, p0_wdata};

    dram_acc_check #(
        .ADDR_W (ADDR_W)
    ) u_check (
        .we      (win_req.we),
        .op      (win_req.op),
        .addr    (win_req.addr),
        .illegal (illegal)
    );

    assign legal     = gnt_any && !illegal;
    assign mem_wr    = legal && win_req.we;
    assign mem_rd    = legal && !win_req.we;
    assign mem_op    = gnt_any ? win_req.op    : 3'b000;
    assign mem_addr  = gnt_any ? win_req.addr  : 32'h0;
    assign mem_wdata = gnt_any ? win_req.wdata : 32'h0;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            rr_last  <= PORT1;
            wait_cnt <= 8'd0;
            rsp_vld  <= 1'b0;
            rsp_id   <= PORT0;
            rsp_err  <= 1'b0;
            rsp_rd   <= 1'b0;
        end else begin
            rsp_vld <= gnt_any;
            rsp_err <= gnt_any && illegal;
            rsp_rd  <= legal && !win_req.we;
            if (gnt_any) begin
                rsp_id  <= win;
                rr_last <= win;
            end
            if (!p1_req || p1_gnt) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != 8'hff) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign p0_rvalid = rsp_vld && (rsp_id == PORT0);
    assign p1_rvalid = rsp_vld && (rsp_id == PORT1);
    assign p0_err    = p0_rvalid && rsp_err;
    assign p1_err    = p1_rvalid && rsp_err;
    assign p0_rdata  = (p0_rvalid && rsp_rd) ? mem_rdata : 32'h0;
    assign p1_rdata  = (p1_rvalid && rsp_rd) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: behavioural RAM wrapper plus a transaction-level
// reference model; a second instance exercises fixed priority with MAX_WAIT=3.
module tb_dram_arbiter;
    import dram_pkg::*;

    localparam int ADDR_W = 14;

    logic sclk = 1'b0;
    logic rstn = 1'b0;
    always #5 sclk = ~sclk;

    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [2:0]  p0_op = 3'b0;
    logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0;
    logic        p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [2:0]  p1_op = 3'b0;
    logic [31:0] p1_addr = 32'h0, p1_wdata = 32'h0;
    logic        p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_rdata;
    logic        mem_wr, mem_rd;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    logic        q0_req = 1'b0, q1_req = 1'b0;
    logic        q0_gnt, q0_rvalid, q0_err, q1_gnt, q1_rvalid, q1_err;
    logic [31:0] q0_rdata, q1_rdata;
    logic        b_mem_wr, b_mem_rd;
    logic [2:0]  b_mem_op;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [31:0] b_mem_rdata = 32'h0;

    dram_arbiter #(.ADDR_W(ADDR_W), .PRIO_MODE(0), .MAX_WAIT(8)) dut (
        .sclk(sclk), .rstn(rstn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_op(p0_op), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_op(p1_op), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dram_arbiter #(.ADDR_W(ADDR_W), .PRIO_MODE(1), .MAX_WAIT(3)) dut_prio (
        .sclk(sclk), .rstn(rstn),
        .p0_req(q0_req), .p0_we(1'b0), .p0_op(OP_LW), .p0_addr(32'h0), .p0_wdata(32'h0),
        .p0_gnt(q0_gnt), .p0_rvalid(q0_rvalid), .p0_err(q0_err), .p0_rdata(q0_rdata),
        .p1_req(q1_req), .p1_we(1'b0), .p1_op(OP_LW), .p1_addr(32'h4), .p1_wdata(32'h0),
        .p1_gnt(q1_gnt), .p1_rvalid(q1_rvalid), .p1_err(q1_err), .p1_rdata(q1_rdata),
        .mem_wr(b_mem_wr), .mem_rd(b_mem_rd), .mem_op(b_mem_op), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Only the low 256 bytes are exercised; every in-range address used fits there.
    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] wa;
    assign wa = mem_addr[7:0];

    function automatic logic [31:0] ld_ext(input logic [2:0] op, input logic [31:0] w);
        case (op)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic we, input logic [2:0] op, input logic [31:0] addr);
        bit op_ok;
        int size;
        op_ok = we ? (op <= 3'd2) : ((op <= 3'd2) || (op == 3'd4) || (op == 3'd5));
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        return !op_ok || ((addr % 32'(size)) != 0) || (addr >= 32'(2 ** ADDR_W));
    endfunction

    // RAM wrapper: stores land at the clock edge, loads return the following cycle.
    always @(posedge sclk) begin
        if (mem_wr) begin
            ram[wa] <= mem_wdata[7:0];
            if (mem_op[1:0] != 2'd0) ram[wa + 8'd1] <= mem_wdata[15:8];
            if (mem_op[1:0] == 2'd2) begin
                ram[wa + 8'd2] <= mem_wdata[23:16];
                ram[wa + 8'd3] <= mem_wdata[31:24];
            end
        end
        if (mem_rd) begin
            mem_rdata <= ld_ext(mem_op, {ram[wa + 8'd3], ram[wa + 8'd2], ram[wa + 8'd1], ram[wa]});
        end
    end

    logic        m_rr_last;
    logic        exp_vld, exp_id, exp_err;
    logic [31:0] exp_rdata;

    logic        s_gnt0, s_gnt1, s_wr, s_rd, s_rv0, s_rv1, s_err0, s_err1;
    logic [31:0] s_addr, s_rdata0, s_rdata1;

    task automatic model_reset();
        m_rr_last = 1'b1;
        exp_vld   = 1'b0;
        exp_id    = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
    endtask

    // One clock of port A: check outputs at negedge against the model, then advance it.
    task automatic cycle(output logic g0, output logic g1);
        logic any, win, ill, we;
        logic [2:0] op;
        logic [31:0] addr, wdata;
        logic [7:0] a;
        logic [32:0] resp;
        @(negedge sclk);
        s_gnt0 = p0_gnt;  s_gnt1 = p1_gnt;  s_wr = mem_wr;  s_rd = mem_rd;
        s_rv0 = p0_rvalid; s_rv1 = p1_rvalid; s_err0 = p0_err; s_err1 = p1_err;
        s_addr = mem_addr; s_rdata0 = p0_rdata; s_rdata1 = p1_rdata;
        any   = p0_req || p1_req;
        win   = (p0_req && p1_req) ? !m_rr_last : p1_req;
        we    = win ? p1_we : p0_we;
        op    = win ? p1_op : p0_op;
        addr  = win ? p1_addr : p0_addr;
        wdata = win ? p1_wdata : p0_wdata;
        ill   = ref_illegal(we, op, addr);
        g0 = any && !win;
        g1 = any && win;
        vec_cnt++;
        if ({p0_gnt, p1_gnt, mem_wr, mem_rd} !== {g0, g1, any && !ill && we, any && !ill && !we}) begin
            err_cnt++;
            $display("FAIL grant_strobes: got gnt0/gnt1/wr/rd=%b, want %b", {p0_gnt, p1_gnt, mem_wr, mem_rd},
                     {g0, g1, any && !ill && we, any && !ill && !we});
        end
        if (!any || !ill) begin
            vec_cnt++;
            if ({mem_op, mem_addr, mem_wdata} !== (any ? {op, addr, wdata} : 67'h0)) begin
                err_cnt++;
                $display("FAIL mem_bus: got op=%h addr=%h wdata=%h, want op=%h addr=%h wdata=%h",
                         mem_op, mem_addr, mem_wdata, any ? op : 3'h0, any ? addr : 32'h0, any ? wdata : 32'h0);
            end
        end
        vec_cnt++;
        if ({p0_rvalid, p1_rvalid} !== {exp_vld && !exp_id, exp_vld && exp_id}) begin
            err_cnt++;
            $display("FAIL rvalid: got %b, want %b", {p0_rvalid, p1_rvalid}, {exp_vld && !exp_id, exp_vld && exp_id});
        end
        if (exp_vld) begin
            resp = exp_id ? {p1_err, p1_rdata} : {p0_err, p0_rdata};
            vec_cnt++;
            if (resp !== {exp_err, exp_rdata}) begin
                err_cnt++;
                $display("FAIL response p%0d: got err=%b rdata=%h, want err=%b rdata=%h",
                         exp_id, resp[32], resp[31:0], exp_err, exp_rdata);
            end
        end
        exp_vld = any;
        if (any) begin
            m_rr_last = win;
            exp_id    = win;
            exp_err   = ill;
            exp_rdata = 32'h0;
            if (!ill) begin
                a = addr[7:0];
                if (we) begin
                    ref_mem[a] = wdata[7:0];
                    if (op[1:0] != 2'd0) ref_mem[a + 8'd1] = wdata[15:8];
                    if (op[1:0] == 2'd2) begin
                        ref_mem[a + 8'd2] = wdata[23:16];
                        ref_mem[a + 8'd3] = wdata[31:24];
                    end
                end else begin
                    exp_rdata = ld_ext(op, {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]});
                end
            end
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic set_req(input int port, input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_op = op; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_op = op; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic new_rand_req(input int port);
        logic we;
        logic [2:0] op;
        logic [31:0] addr;
        logic [2:0] ld_ops [5];
        int sz;
        ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(0, 7));
        else op = we ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
        addr = ($urandom_range(0, 9) == 0) ? 32'h4000 + $urandom_range(0, 255) : $urandom_range(0, 255);
        sz = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        if ($urandom_range(0, 4) != 0) addr = addr & ~32'(sz - 1);
        set_req(port, we, op, addr, $urandom);
    endtask

    task automatic pulse_reset();
        @(posedge sclk);
        #1;
        rstn = 1'b0;
        model_reset();
        @(negedge sclk);
        vec_cnt++;
        if ({p0_rvalid, p1_rvalid, q0_rvalid, q1_rvalid} !== 4'b0) begin
            err_cnt++;
            $display("FAIL rvalid_in_reset: got %b, want 0000", {p0_rvalid, p1_rvalid, q0_rvalid, q1_rvalid});
        end
        @(posedge sclk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        set_req(0, 1'b0, OP_LW, 32'h10, 32'h0);
        set_req(1, 1'b1, OP_SW, 32'h20, 32'hffffffff);
        q0_req = 1'b1;
        q1_req = 1'b1;
        model_reset();
        repeat (2) @(negedge sclk);
        vec_cnt++;
        if ({p0_gnt, p1_gnt, q0_gnt, q1_gnt, mem_wr, mem_rd, b_mem_wr, b_mem_rd} !== 8'h0) begin
            err_cnt++;
            $display("FAIL reset_strobes: got %b, want 00000000",
                     {p0_gnt, p1_gnt, q0_gnt, q1_gnt, mem_wr, mem_rd, b_mem_wr, b_mem_rd});
        end
        vec_cnt++;
        if ({p0_rvalid, p1_rvalid, p0_err, p1_err, mem_op, mem_addr, mem_wdata, p0_rdata, p1_rdata} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got rvalid=%b err=%b addr=%h wdata=%h rdata0=%h rdata1=%h, want all 0",
                     {p0_rvalid, p1_rvalid}, {p0_err, p1_err}, mem_addr, mem_wdata, p0_rdata, p1_rdata);
        end
        p0_req = 1'b0; p1_req = 1'b0; q0_req = 1'b0; q1_req = 1'b0;
        @(posedge sclk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_lw_basic();
        logic g0, g1;
        set_req(0, 1'b0, OP_LW, 32'h10, 32'h0);
        cycle(g0, g1);
        vec_cnt++;
        if ({s_gnt0, s_gnt1, s_rd, s_wr, s_addr} !== {4'b1010, 32'h10}) begin
            err_cnt++;
            $display("FAIL lw_grant: got gnt0=%b gnt1=%b rd=%b wr=%b addr=%h, want 1 0 1 0 00000010",
                     s_gnt0, s_gnt1, s_rd, s_wr, s_addr);
        end
        p0_req = 1'b0;
        cycle(g0, g1);
        vec_cnt++;
        if ({s_rv0, s_err0, s_rdata0, s_rv1, s_err1, s_rdata1} !== {2'b10, 32'hdeadbeef, 2'b00, 32'h0}) begin
            err_cnt++;
            $display("FAIL lw_response: got rv0=%b err0=%b rdata0=%h rv1=%b rdata1=%h, want 1 0 deadbeef 0 0",
                     s_rv0, s_err0, s_rdata0, s_rv1, s_rdata1);
        end
    endtask

    task automatic test_round_robin();
        logic g0, g1;
        logic [3:0] seq;
        pulse_reset();
        set_req(0, 1'b0, OP_LW, 32'h10, 32'h0);
        set_req(1, 1'b0, OP_LW, 32'h14, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(g0, g1);
            seq[3 - i] = s_gnt1;
        end
        vec_cnt++;
        if (seq !== 4'b0101) begin
            err_cnt++;
            $display("FAIL rr_order: got p1-grant sequence %b, want 0101", seq);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        cycle(g0, g1);
    endtask

    task automatic test_fixed_prio();
        logic [1:0] prev;
        pulse_reset();
        q0_req = 1'b1;
        q1_req = 1'b1;
        prev = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge sclk);
            vec_cnt++;
            if ({q0_gnt, q1_gnt} !== ((i % 4 == 3) ? 2'b01 : 2'b10)) begin
                err_cnt++;
                $display("FAIL prio_grant[%0d]: got %b, want %b", i, {q0_gnt, q1_gnt},
                         (i % 4 == 3) ? 2'b01 : 2'b10);
            end
            vec_cnt++;
            if ({q0_rvalid, q1_rvalid} !== prev) begin
                err_cnt++;
                $display("FAIL prio_rvalid[%0d]: got %b, want %b", i, {q0_rvalid, q1_rvalid}, prev);
            end
            prev = (i % 4 == 3) ? 2'b01 : 2'b10;
            @(posedge sclk);
            #1;
        end
        q0_req = 1'b0;
        q1_req = 1'b0;
    endtask

    task automatic test_illegal();
        logic g0, g1;
        logic        ws [3];
        logic [2:0]  ops [3];
        logic [31:0] as [3];
        ws = '{1'b1, 1'b0, 1'b0};
        ops = '{OP_SH, OP_LW, 3'b011};
        as = '{32'h3, 32'h4000, 32'h8};
        for (int i = 0; i < 3; i++) begin
            set_req(1, ws[i], ops[i], as[i], 32'hcafef00d);
            cycle(g0, g1);
            vec_cnt++;
            if ({s_gnt1, s_wr, s_rd} !== 3'b100) begin
                err_cnt++;
                $display("FAIL illegal_grant[%0d]: got gnt1/wr/rd=%b, want 100", i, {s_gnt1, s_wr, s_rd});
            end
            p1_req = 1'b0;
            cycle(g0, g1);
            vec_cnt++;
            if ({s_rv1, s_err1, s_rdata1} !== {2'b11, 32'h0}) begin
                err_cnt++;
                $display("FAIL illegal_resp[%0d]: got rv1=%b err1=%b rdata1=%h, want 1 1 0", i, s_rv1, s_err1, s_rdata1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic g0, g1;
        set_req(0, 1'b1, OP_SW, 32'h20, 32'h12345678);
        cycle(g0, g1);
        p0_req = 1'b0;
        set_req(1, 1'b0, OP_LBU, 32'h21, 32'h0);
        cycle(g0, g1);
        vec_cnt++;
        if ({s_gnt1, s_rv0, s_err0} !== 3'b110) begin
            err_cnt++;
            $display("FAIL b2b_overlap: got gnt1/rv0/err0=%b, want 110", {s_gnt1, s_rv0, s_err0});
        end
        p1_req = 1'b0;
        cycle(g0, g1);
        vec_cnt++;
        if ({s_rv1, s_rdata1} !== {1'b1, 32'h00000056}) begin
            err_cnt++;
            $display("FAIL b2b_lbu: got rv1=%b rdata1=%h, want 1 00000056", s_rv1, s_rdata1);
        end
    endtask

    task automatic test_reset_mid();
        logic g0, g1;
        set_req(0, 1'b0, OP_LW, 32'h10, 32'h0);
        cycle(g0, g1);
        p0_req = 1'b0;
        rstn = 1'b0;
        model_reset();
        #1;
        vec_cnt++;
        if (p0_rvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset_rvalid: got %b, want 0", p0_rvalid);
        end
        @(posedge sclk);
        #1;
        rstn = 1'b1;
        @(negedge sclk);
        vec_cnt++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            err_cnt++;
            $display("FAIL post_reset_rvalid: got %b, want 00", {p0_rvalid, p1_rvalid});
        end
        @(posedge sclk);
        #1;
        set_req(0, 1'b0, OP_LW, 32'h10, 32'h0);
        set_req(1, 1'b0, OP_LW, 32'h14, 32'h0);
        cycle(g0, g1);
        vec_cnt++;
        if ({s_gnt0, s_gnt1} !== 2'b10) begin
            err_cnt++;
            $display("FAIL post_reset_rr: got gnt0/gnt1=%b, want 10", {s_gnt0, s_gnt1});
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        cycle(g0, g1);
    endtask

    task automatic test_random();
        logic g0, g1;
        for (int i = 0; i < 400; i++) begin
            cycle(g0, g1);
            if (g0 || !p0_req) begin
                if ($urandom_range(0, 3) != 0) new_rand_req(0);
                else p0_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                p0_req = 1'b0;
            end
            if (g1 || !p1_req) begin
                if ($urandom_range(0, 3) != 0) new_rand_req(1);
                else p1_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                p1_req = 1'b0;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        cycle(g0, g1);
        cycle(g0, g1);
    endtask

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            ram[i]     <= b;
            ref_mem[i] = b;
        end
        ram[16] <= 8'hef; ram[17] <= 8'hbe; ram[18] <= 8'had; ram[19] <= 8'hde;
        ref_mem[16] = 8'hef; ref_mem[17] = 8'hbe; ref_mem[18] = 8'had; ref_mem[19] = 8'hde;
        test_reset();
        test_lw_basic();
        test_round_robin();
        test_fixed_prio();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
